// File: rtl/if_stage_if.sv
// Fetch-stage bus: redirect request, instruction-ROM port and the
// valid/ready handshake towards decode.
// master = fetch stage side, slave = environment (branch unit, ROM, decode).
interface if_stage_if #(
  parameter int IMEM_AW = 6
);
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               if_valid;
  logic               if_ready;
  logic [31:0]        if_instr;
  logic [31:0]        if_pc;

  modport master (
    input  redirect_valid, redirect_pc, imem_rdata, if_ready,
    output imem_addr, if_valid, if_instr, if_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_rdata, if_ready,
    input  imem_addr, if_valid, if_instr, if_pc
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives an asynchronous instruction ROM from the
// PC, captures one instruction per step into a valid/ready output register,
// and accepts branch/jump redirects. step_en=0 freezes every register.
// Optional build macro IF_MISALIGN_TRAP_EN: a misaligned redirect sets the
// sticky misalign flag and halts fetching until reset. Without it the low
// two redirect bits are dropped and misalign is constant 0.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 6
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        step_en,
  output logic [31:0] fetch_cnt,
  output logic        misalign,
  if_stage_if.master  bus
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  // PC space covers exactly the ROM, so increments and redirects wrap in it.
  localparam logic [31:0] PC_MASK =
    (IMEM_AW >= 30) ? 32'hFFFF_FFFF : ((32'd1 << (IMEM_AW + 2)) - 32'd1);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        misalign_q, misalign_d;

  logic        redirect_bad;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = bus.redirect_pc & ~32'h3 & PC_MASK;

`ifdef IF_MISALIGN_TRAP_EN
  assign redirect_bad = (bus.redirect_pc[1:0] != 2'b00);
`else
  assign redirect_bad = 1'b0;
`endif

  // Next-state: boot handshake, then redirect > fetch > stall in RUN.
  always_comb begin
    // NOTE: every variable gets its default first, so no path can infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    if_valid_d  = if_valid_q;
    if_instr_d  = if_instr_q;
    if_pc_d     = if_pc_q;
    fetch_cnt_d = fetch_cnt_q;
    misalign_d  = misalign_q;
    if (step_en) begin
      case (state_q)
        BOOT: state_d = RUN;
        RUN: begin
          if (bus.redirect_valid) begin
            if_valid_d = 1'b0;
            if (redirect_bad) begin
              misalign_d = 1'b1;
              state_d    = HALT;
            end else begin
              pc_d = redirect_tgt;
            end
          end else if (!if_valid_q || bus.if_ready) begin
            if_instr_d  = bus.imem_rdata;
            if_pc_d     = pc_q;
            if_valid_d  = 1'b1;
            pc_d        = (pc_q + 32'd4) & PC_MASK;
            fetch_cnt_d = fetch_cnt_q + 32'd1;
          end
        end
        HALT: state_d = HALT;
        default: state_d = BOOT;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rstn) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      if_valid_q  <= 1'b0;
      if_instr_q  <= 32'd0;
      if_pc_q     <= 32'd0;
      fetch_cnt_q <= 32'd0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      if_pc_q     <= if_pc_d;
      fetch_cnt_q <= fetch_cnt_d;
      misalign_q  <= misalign_d;
    end
  end

  assign bus.imem_addr = pc_q[IMEM_AW+1:2];
  assign bus.if_valid  = if_valid_q;
  assign bus.if_instr  = if_instr_q;
  assign bus.if_pc     = if_pc_q;
  assign fetch_cnt     = fetch_cnt_q;
  assign misalign      = misalign_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage with a bench-side ROM model.
module tb_if_stage;

  logic        clk;
  logic        rstn;
  logic        step_en;
  logic [31:0] fetch_cnt;
  logic        misalign;
  int          checks;
  int          failures;

  if_stage_if #(.IMEM_AW(6)) bus ();

  if_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(6)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .step_en   (step_en),
    .fetch_cnt (fetch_cnt),
    .misalign  (misalign),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input int idx);
    if (idx == 0) return 32'h0050_0093;
    return 32'hA000_0000 | 32'(idx);
  endfunction

  assign bus.imem_rdata = rom_word(int'(bus.imem_addr));

  // Advance one edge, then sample/drive 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packed view of the output register: {valid, pc, instr, cnt}.
  function automatic logic [96:0] outv();
    return {bus.if_valid, bus.if_pc, bus.if_instr, fetch_cnt};
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    step_en = 1'b1;
    bus.if_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;
    #3;
    checks++;
    if ({outv(), misalign, bus.imem_addr} !== {1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 6'd0}) begin
      failures++;
      $display("FAIL reset_state: got %h want all zero", {outv(), misalign, bus.imem_addr});
    end
  endtask

  task automatic test_boot();
    step(); // still in reset
    rstn = 1'b1;
    step(); // BOOT -> RUN, no capture
    checks++;
    if (outv() !== {1'b0, 32'd0, 32'd0, 32'd0}) begin
      failures++;
      $display("FAIL boot_no_capture: got %h want %h", outv(), {1'b0, 32'd0, 32'd0, 32'd0});
    end
    step();
    checks++;
    if (outv() !== {1'b1, 32'd0, 32'h0050_0093, 32'd1}) begin
      failures++;
      $display("FAIL first_capture: got %h want %h", outv(), {1'b1, 32'd0, 32'h0050_0093, 32'd1});
    end
  endtask

  task automatic test_stall();
    step(); // capture at pc=4
    checks++;
    if (outv() !== {1'b1, 32'd4, rom_word(1), 32'd2}) begin
      failures++;
      $display("FAIL capture_pc4: got %h want %h", outv(), {1'b1, 32'd4, rom_word(1), 32'd2});
    end
    bus.if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({outv(), bus.imem_addr} !== {1'b1, 32'd4, rom_word(1), 32'd2, 6'd2}) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got %h want %h", i, {outv(), bus.imem_addr},
                 {1'b1, 32'd4, rom_word(1), 32'd2, 6'd2});
      end
    end
    bus.if_ready = 1'b1;
    step();
    checks++;
    if (outv() !== {1'b1, 32'd8, rom_word(2), 32'd3}) begin
      failures++;
      $display("FAIL stall_release: got %h want %h", outv(), {1'b1, 32'd8, rom_word(2), 32'd3});
    end
  endtask

  task automatic test_redirect();
    // Redirect while stalled: redirect wins.
    bus.if_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h20;
    step();
    checks++;
    if ({outv(), bus.imem_addr} !== {1'b0, 32'd8, rom_word(2), 32'd3, 6'd8}) begin
      failures++;
      $display("FAIL redirect_take: got %h want %h", {outv(), bus.imem_addr},
               {1'b0, 32'd8, rom_word(2), 32'd3, 6'd8});
    end
    // if_ready is ignored while if_valid=0.
    bus.redirect_valid = 1'b0;
    step();
    checks++;
    if (outv() !== {1'b1, 32'h20, rom_word(8), 32'd4}) begin
      failures++;
      $display("FAIL redirect_capture: got %h want %h", outv(), {1'b1, 32'h20, rom_word(8), 32'd4});
    end
    // Upper bits beyond the ROM space are dropped.
    bus.if_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0120;
    step();
    checks++;
    if ({bus.if_valid, bus.imem_addr} !== {1'b0, 6'd8}) begin
      failures++;
      $display("FAIL redirect_trunc: got %h want %h", {bus.if_valid, bus.imem_addr}, {1'b0, 6'd8});
    end
    bus.redirect_valid = 1'b0;
    step();
    checks++;
    if (outv() !== {1'b1, 32'h20, rom_word(8), 32'd5}) begin
      failures++;
      $display("FAIL redirect_trunc_cap: got %h want %h", outv(), {1'b1, 32'h20, rom_word(8), 32'd5});
    end
  endtask

  task automatic test_wrap();
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    step(); // BOOT
    for (int k = 1; k <= 64; k++) step();
    checks++;
    if ({outv(), bus.imem_addr} !== {1'b1, 32'hFC, rom_word(63), 32'd64, 6'd0}) begin
      failures++;
      $display("FAIL wrap_last: got %h want %h", {outv(), bus.imem_addr},
               {1'b1, 32'hFC, rom_word(63), 32'd64, 6'd0});
    end
    step();
    checks++;
    if (outv() !== {1'b1, 32'h0, rom_word(0), 32'd65}) begin
      failures++;
      $display("FAIL wrap_first: got %h want %h", outv(), {1'b1, 32'h0, rom_word(0), 32'd65});
    end
  endtask

  task automatic test_pause();
    step_en = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({outv(), misalign, bus.imem_addr} !== {1'b1, 32'h0, rom_word(0), 32'd65, 1'b0, 6'd1}) begin
        failures++;
        $display("FAIL pause_hold[%0d]: got %h want %h", i, {outv(), misalign, bus.imem_addr},
                 {1'b1, 32'h0, rom_word(0), 32'd65, 1'b0, 6'd1});
      end
    end
    step_en = 1'b1;
    step();
    checks++;
    if ({bus.if_valid, bus.imem_addr, fetch_cnt} !== {1'b0, 6'h10, 32'd65}) begin
      failures++;
      $display("FAIL pause_redirect: got %h want %h", {bus.if_valid, bus.imem_addr, fetch_cnt},
               {1'b0, 6'h10, 32'd65});
    end
    bus.redirect_valid = 1'b0;
    step();
    checks++;
    if (outv() !== {1'b1, 32'h40, rom_word(16), 32'd66}) begin
      failures++;
      $display("FAIL pause_capture: got %h want %h", outv(), {1'b1, 32'h40, rom_word(16), 32'd66});
    end
  endtask

  task automatic test_misalign();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h22;
    step();
    bus.redirect_valid = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
    checks++;
    if ({misalign, bus.if_valid, bus.imem_addr, fetch_cnt} !== {1'b1, 1'b0, 6'h11, 32'd66}) begin
      failures++;
      $display("FAIL misalign_trap: got %h want %h", {misalign, bus.if_valid, bus.imem_addr, fetch_cnt},
               {1'b1, 1'b0, 6'h11, 32'd66});
    end
    for (int i = 0; i < 3; i++) step();
    checks++;
    if ({misalign, bus.if_valid, fetch_cnt} !== {1'b1, 1'b0, 32'd66}) begin
      failures++;
      $display("FAIL misalign_halt: got %h want %h", {misalign, bus.if_valid, fetch_cnt},
               {1'b1, 1'b0, 32'd66});
    end
`else
    checks++;
    if ({misalign, bus.if_valid, bus.imem_addr} !== {1'b0, 1'b0, 6'h08}) begin
      failures++;
      $display("FAIL misalign_drop: got %h want %h", {misalign, bus.if_valid, bus.imem_addr},
               {1'b0, 1'b0, 6'h08});
    end
    step();
    checks++;
    if ({outv(), misalign} !== {1'b1, 32'h20, rom_word(8), 32'd67, 1'b0}) begin
      failures++;
      $display("FAIL misalign_capture: got %h want %h", {outv(), misalign},
               {1'b1, 32'h20, rom_word(8), 32'd67, 1'b0});
    end
`endif
  endtask

  task automatic test_reset_mid_stall();
    bus.if_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({outv(), misalign, bus.imem_addr} !== {1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 6'd0}) begin
      failures++;
      $display("FAIL reset_async: got %h want all zero", {outv(), misalign, bus.imem_addr});
    end
    bus.redirect_valid = 1'b0;
    bus.if_ready = 1'b1;
    step();
    rstn = 1'b1;
    step(); // BOOT
    step();
    checks++;
    if (outv() !== {1'b1, 32'd0, 32'h0050_0093, 32'd1}) begin
      failures++;
      $display("FAIL reset_restart: got %h want %h", outv(), {1'b1, 32'd0, 32'h0050_0093, 32'd1});
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_boot();
    test_stall();
    test_redirect();
    test_wrap();
    test_pause();
    test_misalign();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 The block SHALL have parameter IMEM_AW, default 6, meaning the instruction-ROM word-address width (64 words).
REQ-003 The block SHALL have port clk  input  1  rising-edge clock, which is the CPU step clock.
REQ-004 The block SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port step_en  input  1  pause control; 0 freezes all state.
REQ-006 The block SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-007 The block SHALL have port redirect_pc  input  32  byte address of the redirect target.
REQ-008 The block SHALL have port imem_addr  output  IMEM_AW  word address to the asynchronous ROM, equal to pc[IMEM_AW+1:2].
REQ-009 The block SHALL have port imem_rdata  input  32  combinational ROM data for imem_addr.
REQ-010 The block SHALL have port if_valid  output  1  the instruction register holds a valid instruction.
REQ-011 The block SHALL have port if_ready  input  1  the downstream decode stage accepts the instruction this cycle.
REQ-012 The block SHALL have port if_instr  output  32  the fetched instruction.
REQ-013 The block SHALL have port if_pc  output  32  the byte PC of if_instr.
REQ-014 The block SHALL have port fetch_cnt  output  32  count of instructions captured since reset, for display.
REQ-015 The block SHALL have port misalign  output  1  sticky misaligned-redirect flag.

Function
REQ-016 The FSM SHALL have states BOOT, RUN and HALT; reset enters BOOT; BOOT goes to RUN on the first cycle with step_en=1, with no capture in that cycle.
REQ-017 A fetch SHALL occur in RUN when step_en=1, redirect_valid=0 and (if_valid=0 or if_ready=1), and only then.
REQ-018 On a fetch, if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4 and fetch_cnt<=fetch_cnt+1, giving a latency of one cycle from address to if_valid.
REQ-019 The PC increment SHALL wrap modulo 2^(IMEM_AW+2), so the last word (pc=0xFC by default) is followed by pc=0x00; fetch_cnt SHALL wrap at 2^32.
REQ-020 When if_valid=1 and if_ready=0, pc, if_instr, if_pc and fetch_cnt SHALL hold (stall).
REQ-021 When if_valid=0, if_ready SHALL be ignored.
REQ-022 A redirect SHALL occur when step_en=1 and redirect_valid=1 in RUN: pc<=redirect_pc with the upper bits truncated per REQ-019, if_valid<=0, and no capture or count in that cycle.
REQ-023 A redirect SHALL take priority over a fetch and over a stall.
REQ-024 redirect_valid SHALL be ignored while step_en=0 or in BOOT/HALT; the requester holds it until step_en=1.
REQ-025 With step_en=0, no register SHALL change.
REQ-026 if_ready=1 together with a fetch in the same cycle SHALL accept the old instruction and capture the new one back-to-back, with no bubble.
REQ-027 HALT SHALL be left only by reset.

Reset
REQ-028 While rstn=0, pc=RESET_PC, state=BOOT, if_valid=0, if_instr=0, if_pc=0, fetch_cnt=0 and misalign=0, all asynchronously.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL discard the pending instruction and the redirect.
REQ-030 The first captured instruction after reset SHALL be ROM[RESET_PC>>2].

Configuration
REQ-031 Macro IF_MISALIGN_TRAP_EN defined: a redirect with redirect_pc[1:0]!=0 SHALL set misalign=1, clear if_valid, leave pc unchanged and enter HALT.
REQ-032 Macro IF_MISALIGN_TRAP_EN undefined: redirect_pc[1:0] SHALL be treated as 2'b00, misalign SHALL be tied 0, and HALT SHALL be unreachable.

Verification
REQ-033 Scenario (reset release): ROM[0]=0x00500093, step_en=1, if_ready=1 -> BOOT for one cycle, next edge if_valid=1, if_instr=0x00500093, if_pc=0, fetch_cnt=1.
REQ-034 Scenario (stall): if_ready=0 for 3 cycles after capture at pc=4 -> if_pc stays 4 and fetch_cnt is unchanged; on if_ready=1, if_pc=8 on the next edge.
REQ-035 Scenario (redirect): redirect_valid=1, redirect_pc=0x20 while if_valid=1 -> next edge if_valid=0, then next capture if_pc=0x20 with if_instr=ROM[8].
REQ-036 Scenario (wrap): run through pc=0xFC -> the following capture has if_pc=0x00 and fetch_cnt=65.
REQ-037 Scenario (pause): step_en=0 for 10 cycles with redirect_valid=1 -> all outputs unchanged and the redirect is not taken until step_en=1.
REQ-038 Scenario (misalign, macro defined): redirect_pc=0x22 -> misalign=1, if_valid=0, no further captures until rstn=0; with the macro undefined, the next capture has if_pc=0x20.
